// File: rtl/dlfloat_pkg.sv
// Shared DLFloat types: 16-bit word (1 sign, 6 exponent, 9 mantissa) and the
// operand-pair record carried from the loader FIFO to the MAC.
package dlfloat_pkg;
  localparam int DLF_W      = 16;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;
  localparam int DLF_BIAS   = 31;

  typedef logic [DLF_W-1:0] dlf_t;

  typedef struct packed {
    dlf_t a;
    dlf_t b;
    logic last;
    logic zero;
  } dlf_pair_t;

  // Only the all-zero pattern counts; -0 (8000) is deliberately not zero.
  function automatic logic dlf_is_zero(dlf_t w);
    return (w == '0);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO with extra-MSB pointers; head data reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never reset; empty gating keeps stale words off the outputs.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/dlfloat_operand_loader.sv
// Pairs consecutive DLFloat words into (A,B) operands, tags zero products and
// batch ends, and queues pairs for the MAC behind a valid/ready handshake.
module dlfloat_operand_loader
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DLF_W-1:0]       data_in,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [DLF_W-1:0]       op_a,
  output logic [DLF_W-1:0]       op_b,
  output logic                   op_last,
  output logic                   op_zero,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_last
);
  localparam logic [0:0] PH_A = 1'b0;
  localparam logic [0:0] PH_B = 1'b1;

  logic [0:0] phase;
  dlf_t       hold_a;
  logic       full;
  logic       empty;
  logic       accept;
  logic       push;
  dlf_pair_t  push_pair;
  dlf_pair_t  head;

  // Full only blocks the B word; op_ready never feeds back into in_ready.
  assign in_ready = (phase == PH_A) || !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (phase == PH_B);

  assign push_pair.a    = hold_a;
  assign push_pair.b    = data_in;
  assign push_pair.last = in_last;
  assign push_pair.zero = dlf_is_zero(hold_a) || dlf_is_zero(data_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_A;
      hold_a   <= '0;
      err_last <= 1'b0;
    end else if (flush) begin
      phase    <= PH_A;
      hold_a   <= '0;
      err_last <= 1'b0;
    end else if (accept) begin
      if (phase == PH_A) begin
        hold_a <= data_in;
        phase  <= PH_B;
        if (in_last) err_last <= 1'b1;
      end else begin
        phase <= PH_A;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(dlf_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (op_ready),
    .wdata (push_pair),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign op_valid = !empty;
  assign op_a     = head.a;
  assign op_b     = head.b;
  assign op_last  = head.last;
  assign op_zero  = head.zero;
endmodule
